// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, turns MEM exceptions into flush/redirect,
// and counts stall cycles. Optional stall watchdog enabled by defining PIPE_CTRL_WDOG_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter int          CNT_W      = 32,
  parameter int          WDOG_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      mem_excepttype,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [1:0]       ctrl_state,
`ifdef PIPE_CTRL_WDOG_EN
  output logic             wdog_fire,
`endif
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    STALL   = 2'b01,
    RECOVER = 2'b10
  } state_t;

  localparam logic [31:0] EXC_ERET = 32'h0000000e;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [5:0]       req_vec;
  logic             wdog_hit;

  // Highest requesting stage wins; the stage just below it then sees a bubble.
  always_comb begin
    if (stallreq_mem)      req_vec = 6'b011111;
    else if (stallreq_ex)  req_vec = 6'b001111;
    else if (stallreq_id)  req_vec = 6'b000111;
    else if (stallreq_if)  req_vec = 6'b000011;
    else                   req_vec = 6'b000000;
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_LIMIT - 1);
  logic [15:0] wdog_cnt_reg;

  // Fires on the WDOG_LIMIT-th consecutive stalled cycle.
  assign wdog_hit  = (wdog_cnt_reg == WDOG_LAST) && (req_vec != 6'b000000);
  assign wdog_fire = !rst && (state_reg != RECOVER) && (mem_excepttype == 32'h0) && wdog_hit;

  always_ff @(posedge clk) begin
    if (rst || flush || stall == 6'b000000) wdog_cnt_reg <= 16'h0;
    else                                    wdog_cnt_reg <= wdog_cnt_reg + 16'h1;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = 32'h0;
    state_next = state_reg;
    if (rst) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        RECOVER: state_next = RUN;
        default: begin
          if (mem_excepttype != 32'h0) begin
            flush      = 1'b1;
            new_pc     = (mem_excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
            state_next = RECOVER;
          end else if (wdog_hit) begin
            flush      = 1'b1;
            new_pc     = EXC_VECTOR;
            state_next = RECOVER;
          end else begin
            stall      = req_vec;
            state_next = (req_vec != 6'b000000) ? STALL : RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= RUN;
      stall_cycles_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (stall != 6'b000000 && !(&stall_cycles_reg))
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
    end
  end

  assign ctrl_state   = state_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule
